// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Merges three register-file write sources onto a single write port.
//   The main pipeline has absolute priority and is never stalled; load
//   returns and mul/div results are queued in an in-order FIFO and drained
//   into the write port whenever the pipeline leaves it idle.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   pipe_wen/pipe_rd/pipe_data   main-pipeline writeback (always accepted)
//   ld_valid/ld_rd/ld_data       load-return request, ld_ready handshake
//   md_valid/md_rd/md_data       mul/div result request, md_ready handshake
//   wen/rd/data_in               registered register-file write port
//   pending_mask                 per-register "write still buffered" flags
module regfile_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        wen,
  output logic [4:0]  rd,
  output logic [31:0] data_in,
  output logic [31:0] pending_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count_q, count_d, free;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, md_idx, offs;
  logic [4:0]    mem_rd_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic          wen_q, wen_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   data_q, data_d;
  logic          ld_push, md_push, pipe_sel, pop;

  // Free space is taken from the current count only, so a same-cycle pop
  // never lets an extra request in.
  assign free     = CW'(DEPTH) - count_q;
  assign ld_ready = (free != '0);
  assign md_ready = (free >= CW'(2)) || ((free == CW'(1)) && !ld_valid);

  // rd==0 requests complete the handshake but are dropped.
  assign ld_push  = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign md_push  = md_valid && md_ready && (md_rd != 5'd0);
  assign pipe_sel = pipe_wen && (pipe_rd != 5'd0);
  assign pop      = !pipe_sel && (count_q != '0);

  // Load entry is older than a simultaneous mul/div entry.
  assign md_idx   = ld_push ? wr_ptr_q + AW'(1) : wr_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(ld_push) + AW'(md_push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(ld_push) + CW'(md_push) - CW'(pop);
    wen_d    = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    if (pipe_sel) begin
      wen_d  = 1'b1;
      rd_d   = pipe_rd;
      data_d = pipe_data;
    end else if (pop) begin
      wen_d  = 1'b1;
      rd_d   = mem_rd_q[rd_ptr_q];
      data_d = mem_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wen_q    <= 1'b0;
      rd_q     <= 5'd0;
      data_q   <= 32'd0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wen_q    <= wen_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (ld_push) begin
      mem_rd_q[wr_ptr_q]   <= ld_rd;
      mem_data_q[wr_ptr_q] <= ld_data;
    end
    if (md_push) begin
      mem_rd_q[md_idx]   <= md_rd;
      mem_data_q[md_idx] <= md_data;
    end
  end

  // An entry is live when its distance from the head is below the count;
  // duplicates simply OR into the same bit.
  always_comb begin
    pending_mask = 32'd0;
    offs         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - rd_ptr_q;
      if ({1'b0, offs} < count_q)
        pending_mask[mem_rd_q[i]] = 1'b1;
    end
  end

  assign wen     = wen_q;
  assign rd      = rd_q;
  assign data_in = data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wen;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] data_in;
  logic [31:0] pending_mask;

  int vecs = 0;
  int errs = 0;

  regfile_write_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .wen(wen), .rd(rd), .data_in(data_in), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wen = 0; pipe_rd = 0; pipe_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    tick(); tick();
    vecs++; if (wen !== 1'b0) begin errs++; $display("FAIL reset_wen got %b exp 0", wen); end
    vecs++; if (rd !== 5'd0) begin errs++; $display("FAIL reset_rd got %0d exp 0", rd); end
    vecs++; if (data_in !== 32'd0) begin errs++; $display("FAIL reset_data got %h exp 0", data_in); end
    vecs++; if (pending_mask !== 32'd0) begin errs++; $display("FAIL reset_pending got %h exp 0", pending_mask); end
    vecs++; if (ld_ready !== 1'b1 || md_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b%b exp 11", ld_ready, md_ready); end
    rst = 0;
  endtask

  task automatic test_pipe_write();
    pipe_wen = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
    tick();
    vecs++; if ({wen, rd, data_in} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errs++; $display("FAIL pipe_write got %b/%0d/%h exp 1/5/deadbeef", wen, rd, data_in); end
    idle();
    tick();
    vecs++; if ({wen, rd, data_in} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin errs++; $display("FAIL pipe_hold got %b/%0d/%h exp 0/5/deadbeef", wen, rd, data_in); end
  endtask

  task automatic test_ld_md_pair();
    ld_valid = 1; ld_rd = 3; ld_data = 32'h11;
    md_valid = 1; md_rd = 4; md_data = 32'h22;
    #1;
    vecs++; if (ld_ready !== 1'b1 || md_ready !== 1'b1) begin errs++; $display("FAIL pair_ready got %b%b exp 11", ld_ready, md_ready); end
    tick();
    idle();
    #1;
    vecs++; if (pending_mask !== 32'h18) begin errs++; $display("FAIL pair_pend0 got %h exp 18", pending_mask); end
    vecs++; if (wen !== 1'b0) begin errs++; $display("FAIL pair_nowrite got %b exp 0", wen); end
    tick();
    vecs++; if ({wen, rd, data_in} !== {1'b1, 5'd3, 32'h11}) begin errs++; $display("FAIL pair_first got %b/%0d/%h exp 1/3/11", wen, rd, data_in); end
    vecs++; if (pending_mask !== 32'h10) begin errs++; $display("FAIL pair_pend1 got %h exp 10", pending_mask); end
    tick();
    vecs++; if ({wen, rd, data_in} !== {1'b1, 5'd4, 32'h22}) begin errs++; $display("FAIL pair_second got %b/%0d/%h exp 1/4/22", wen, rd, data_in); end
    vecs++; if (pending_mask !== 32'h0) begin errs++; $display("FAIL pair_pend2 got %h exp 0", pending_mask); end
    tick();
    vecs++; if (wen !== 1'b0) begin errs++; $display("FAIL pair_drained got %b exp 0", wen); end
  endtask

  task automatic test_pipe_priority();
    for (int k = 0; k < 6; k++) begin
      pipe_wen = 1; pipe_rd = 7; pipe_data = 32'hA0 + k;
      ld_valid = (k < 4); ld_rd = 5'(8 + k); ld_data = 32'h100 + k;
      #1;
      vecs++; if (ld_ready !== (k < 4)) begin errs++; $display("FAIL prio_ld_ready[%0d] got %b exp %b", k, ld_ready, (k < 4)); end
      tick();
      vecs++; if ({wen, rd, data_in} !== {1'b1, 5'd7, 32'hA0 + k}) begin errs++; $display("FAIL prio_pipe[%0d] got %b/%0d/%h exp 1/7/%h", k, wen, rd, data_in, 32'hA0 + k); end
    end
    idle();
    #1;
    vecs++; if (pending_mask !== 32'hF00) begin errs++; $display("FAIL prio_pending got %h exp f00", pending_mask); end
    for (int j = 0; j < 4; j++) begin
      tick();
      vecs++; if ({wen, rd, data_in} !== {1'b1, 5'(8 + j), 32'h100 + j}) begin errs++; $display("FAIL prio_drain[%0d] got %b/%0d/%h exp 1/%0d/%h", j, wen, rd, data_in, 8 + j, 32'h100 + j); end
    end
    tick();
    vecs++; if (wen !== 1'b0) begin errs++; $display("FAIL prio_idle got %b exp 0", wen); end
  endtask

  task automatic test_rd_zero();
    ld_valid = 1; ld_rd = 0; ld_data = 32'h55;
    md_valid = 1; md_rd = 0; md_data = 32'h66;
    #1;
    vecs++; if (ld_ready !== 1'b1 || md_ready !== 1'b1) begin errs++; $display("FAIL zero_ready got %b%b exp 11", ld_ready, md_ready); end
    tick();
    idle();
    #1;
    vecs++; if (pending_mask !== 32'h0) begin errs++; $display("FAIL zero_pending got %h exp 0", pending_mask); end
    tick();
    vecs++; if (wen !== 1'b0) begin errs++; $display("FAIL zero_wen got %b exp 0", wen); end
  endtask

  task automatic test_full();
    pipe_wen = 1; pipe_rd = 1; pipe_data = 32'h1;
    ld_valid = 1; ld_rd = 12; ld_data = 32'hC;
    md_valid = 1; md_rd = 13; md_data = 32'hD;
    tick();
    ld_rd = 14; ld_data = 32'hE; md_rd = 15; md_data = 32'hF;
    #1;
    vecs++; if (md_ready !== 1'b1) begin errs++; $display("FAIL full_md_free2 got %b exp 1", md_ready); end
    tick();
    md_valid = 0; ld_rd = 16; ld_data = 32'h10;
    #1;
    vecs++; if (ld_ready !== 1'b0 || md_ready !== 1'b0) begin errs++; $display("FAIL full_ready got %b%b exp 00", ld_ready, md_ready); end
    vecs++; if (pending_mask !== 32'hF000) begin errs++; $display("FAIL full_pending got %h exp f000", pending_mask); end
    tick();
    pipe_wen = 0;
    #1;
    vecs++; if (ld_ready !== 1'b0) begin errs++; $display("FAIL full_pop_ready got %b exp 0", ld_ready); end
    tick();
    vecs++; if ({wen, rd, data_in} !== {1'b1, 5'd12, 32'hC}) begin errs++; $display("FAIL full_pop got %b/%0d/%h exp 1/12/c", wen, rd, data_in); end
    pipe_wen = 1; pipe_data = 32'h2;
    #1;
    vecs++; if (ld_ready !== 1'b1) begin errs++; $display("FAIL full_count3_ready got %b exp 1", ld_ready); end
    vecs++; if (md_ready !== 1'b0) begin errs++; $display("FAIL full_md_free1 got %b exp 0", md_ready); end
    tick();
    vecs++; if ({wen, rd, data_in} !== {1'b1, 5'd1, 32'h2}) begin errs++; $display("FAIL full_pipe got %b/%0d/%h exp 1/1/2", wen, rd, data_in); end
    idle();
    #1;
    vecs++; if (ld_ready !== 1'b0) begin errs++; $display("FAIL full_refill got %b exp 0", ld_ready); end
    vecs++; if (pending_mask !== 32'h1E000) begin errs++; $display("FAIL full_pending2 got %h exp 1e000", pending_mask); end
    for (int j = 0; j < 4; j++) begin
      tick();
      vecs++; if ({wen, rd, data_in} !== {1'b1, 5'(13 + j), 32'hD + j}) begin errs++; $display("FAIL full_drain[%0d] got %b/%0d/%h exp 1/%0d/%h", j, wen, rd, data_in, 13 + j, 32'hD + j); end
    end
    tick();
    vecs++; if (wen !== 1'b0) begin errs++; $display("FAIL full_idle got %b exp 0", wen); end
  endtask

  task automatic test_duplicate_rd();
    ld_valid = 1; ld_rd = 6; ld_data = 32'h61;
    md_valid = 1; md_rd = 6; md_data = 32'h62;
    tick();
    idle();
    #1;
    vecs++; if (pending_mask !== 32'h40) begin errs++; $display("FAIL dup_pend0 got %h exp 40", pending_mask); end
    tick();
    vecs++; if ({wen, rd, data_in} !== {1'b1, 5'd6, 32'h61}) begin errs++; $display("FAIL dup_first got %b/%0d/%h exp 1/6/61", wen, rd, data_in); end
    vecs++; if (pending_mask !== 32'h40) begin errs++; $display("FAIL dup_pend1 got %h exp 40", pending_mask); end
    tick();
    vecs++; if ({wen, rd, data_in} !== {1'b1, 5'd6, 32'h62}) begin errs++; $display("FAIL dup_second got %b/%0d/%h exp 1/6/62", wen, rd, data_in); end
    vecs++; if (pending_mask !== 32'h0) begin errs++; $display("FAIL dup_pend2 got %h exp 0", pending_mask); end
    tick();
  endtask

  task automatic test_reset_mid();
    pipe_wen = 1; pipe_rd = 2; pipe_data = 32'h22222222;
    ld_valid = 1; ld_rd = 20; ld_data = 32'h20;
    md_valid = 1; md_rd = 21; md_data = 32'h21;
    tick();
    md_valid = 0; ld_rd = 22; ld_data = 32'h22;
    tick();
    idle();
    #1;
    vecs++; if (pending_mask !== 32'h700000) begin errs++; $display("FAIL rmid_pending got %h exp 700000", pending_mask); end
    vecs++; if (wen !== 1'b1) begin errs++; $display("FAIL rmid_prewen got %b exp 1", wen); end
    #2;
    rst = 1;
    #1;
    vecs++; if (wen !== 1'b0 || rd !== 5'd0 || data_in !== 32'd0) begin errs++; $display("FAIL rmid_outputs got %b/%0d/%h exp 0/0/0", wen, rd, data_in); end
    vecs++; if (pending_mask !== 32'h0) begin errs++; $display("FAIL rmid_pend got %h exp 0", pending_mask); end
    vecs++; if (ld_ready !== 1'b1 || md_ready !== 1'b1) begin errs++; $display("FAIL rmid_ready got %b%b exp 11", ld_ready, md_ready); end
    tick();
    rst = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      vecs++; if (wen !== 1'b0 || pending_mask !== 32'h0) begin errs++; $display("FAIL rmid_stale[%0d] got wen %b pend %h exp 0/0", j, wen, pending_mask); end
    end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_ld_md_pair();
    test_pipe_priority();
    test_rd_zero();
    test_full();
    test_duplicate_rd();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
